// File: rtl/fire_control.sv
// Purpose: frame-paced shot scheduler (IDLE/BURST/COOLDOWN) that issues one-cycle fire pulses to a missile bank.
// Latency: shooting_pulse and state flags are registered and appear the cycle after the deciding startOfFrame.
// Backpressure: slot_free low withholds shots (a due burst shot retries each frame); FIRE_CONTROL_RANDOM_EN adds an LFSR gate on burst starts.
module fire_control #(
    parameter int          MAX_BURST        = 3,
    parameter int          BURST_GAP_FRAMES = 2,
    parameter int          COOLDOWN_FRAMES  = 4,
    parameter int          RANDOM_BITS      = 2,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       fire_request,
    input  logic       slot_free,
    output logic       shooting_pulse,
    output logic       burst_active,
    output logic       cooldown_active,
    output logic [7:0] shot_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0] BURST_RELOAD = 8'(MAX_BURST - 1);
    localparam logic [7:0] GAP_RELOAD   = 8'(BURST_GAP_FRAMES - 1);
    localparam logic [7:0] CD_RELOAD    = 8'(COOLDOWN_FRAMES);

    state_t     state, stateNext;
    logic [7:0] shotsLeft, shotsLeftNext;
    logic [7:0] gap, gapNext;
    logic [7:0] cd, cdNext;
    logic       fire;
    logic       randomOk;

`ifdef FIRE_CONTROL_RANDOM_EN
    // A zero seed would lock the LFSR, so substitute 1.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr;
    logic        lfsrFb;

    // Taps for x^16+x^14+x^13+x^11+1 in right-shifting form.
    assign lfsrFb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    // Gate looks at the value before this frame's advance.
    assign randomOk = (lfsr[RANDOM_BITS-1:0] == '0);

    // LFSR advances once per frame regardless of state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED_EFF;
        end else if (startOfFrame) begin
            lfsr <= {lfsrFb, lfsr[15:1]};
        end
    end
`else
    assign randomOk = 1'b1;
`endif

    // Next-state and fire decision; everything holds outside frame-start cycles.
    always_comb begin
        stateNext     = state;
        shotsLeftNext = shotsLeft;
        gapNext       = gap;
        cdNext        = cd;
        fire          = 1'b0;
        if (startOfFrame) begin
            case (state)
                IDLE: begin
                    if (fire_request && slot_free && randomOk) begin
                        fire          = 1'b1;
                        shotsLeftNext = BURST_RELOAD;
                        gapNext       = GAP_RELOAD;
                        if (BURST_RELOAD != 8'd0) begin
                            stateNext = BURST;
                        end else begin
                            stateNext = COOLDOWN;
                            cdNext    = CD_RELOAD;
                        end
                    end
                end
                BURST: begin
                    // A dropped request ends the burst even if a shot is due.
                    if (!fire_request) begin
                        stateNext = COOLDOWN;
                        cdNext    = CD_RELOAD;
                    end else if (gap != 8'd0) begin
                        gapNext = gap - 8'd1;
                    end else if (slot_free) begin
                        fire          = 1'b1;
                        shotsLeftNext = shotsLeft - 8'd1;
                        gapNext       = GAP_RELOAD;
                        if (shotsLeft == 8'd1) begin
                            stateNext = COOLDOWN;
                            cdNext    = CD_RELOAD;
                        end
                    end
                    // gap==0 with no free slot: hold and retry next frame.
                end
                COOLDOWN: begin
                    if (cd == 8'd0) begin
                        stateNext = IDLE;
                    end else begin
                        cdNext = cd - 8'd1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State, counters and the registered fire pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shotsLeft      <= 8'd0;
            gap            <= 8'd0;
            cd             <= 8'd0;
            shooting_pulse <= 1'b0;
            shot_count     <= 8'd0;
        end else begin
            state          <= stateNext;
            shotsLeft      <= shotsLeftNext;
            gap            <= gapNext;
            cd             <= cdNext;
            shooting_pulse <= fire;
            shot_count     <= shot_count + {7'd0, fire};
        end
    end

    assign burst_active    = (state == BURST);
    assign cooldown_active = (state == COOLDOWN);

endmodule

// File: tb/tb_fire_control.sv
// Purpose: scoreboard bench for fire_control; stimulus pushes expected per-frame responses, a monitor pops and compares.
// Latency: each frame's response is checked on the falling edge after the startOfFrame edge.
// Backpressure: slot_free patterns exercise the withheld-shot retry path.
module tb_fire_control;

    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       fire_request;
    logic       slot_free;
    logic       shooting_pulse;
    logic       burst_active;
    logic       cooldown_active;
    logic [7:0] shot_count;

    typedef struct packed {
        logic       fire;
        logic       burst;
        logic       cool;
        logic [7:0] count;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] expCount;
    logic       sofAtEdge = 1'b0;
    logic       monOn     = 1'b0;
    int         total     = 0;
    int         bad       = 0;

    string patP = "1010100000";
    string patS = "BBBBCCCCCI";

`ifdef FIRE_CONTROL_RANDOM_EN
    logic [15:0] lfsrRef;
    int          phase;
    logic        ef;
    byte         st;
`endif

    fire_control dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .fire_request    (fire_request),
        .slot_free       (slot_free),
        .shooting_pulse  (shooting_pulse),
        .burst_active    (burst_active),
        .cooldown_active (cooldown_active),
        .shot_count      (shot_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Issue one frame; the expected response is queued before the frame is driven.
    task automatic frame(input logic req, input logic free, input logic expFire, input byte expSt);
        exp_t e;
        if (expFire) expCount = expCount + 8'd1;
        e.fire  = expFire;
        e.burst = (expSt == "B");
        e.cool  = (expSt == "C");
        e.count = expCount;
        expQ.push_back(e);
        @(negedge clk);
        fire_request = req;
        slot_free    = free;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        // Inputs between frames must be ignored, so scramble them.
        fire_request = ~req;
        slot_free    = ~free;
        repeat (2) @(negedge clk);
    endtask

    task automatic runTable(input string p, input string s, input string rq, input string fr);
        for (int i = 0; i < p.len(); i++) begin
            frame(rq[i] == "1", fr[i] == "1", p[i] == "1", s[i]);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset    = 1'b1;
        expCount = 8'd0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    // Monitor: the response slot is the cycle after a startOfFrame edge.
    always @(posedge clk) sofAtEdge <= startOfFrame;

    always @(negedge clk) begin
        exp_t e;
        if (sofAtEdge) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL response_without_expectation: got a frame response, expected none queued");
            end else begin
                e = expQ.pop_front();
                check("shooting_pulse", {31'd0, shooting_pulse}, {31'd0, e.fire});
                check("burst_active", {31'd0, burst_active}, {31'd0, e.burst});
                check("cooldown_active", {31'd0, cooldown_active}, {31'd0, e.cool});
                check("shot_count", {24'd0, shot_count}, {24'd0, e.count});
            end
        end else if (monOn) begin
            check("pulse_outside_response_slot", {31'd0, shooting_pulse}, 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        fire_request = 1'b1;
        slot_free    = 1'b1;
        expCount     = 8'd0;

        // Frames arriving while reset is held must produce nothing.
        @(negedge clk);
        repeat (3) begin
            expQ.push_back(exp_t'{fire: 1'b0, burst: 1'b0, cool: 1'b0, count: 8'd0});
            startOfFrame = 1'b1;
            @(negedge clk);
        end
        startOfFrame = 1'b0;
        reset        = 1'b0;
        monOn        = 1'b1;
        @(negedge clk);
        check("shot_count_after_reset", {24'd0, shot_count}, 32'd0);

`ifdef FIRE_CONTROL_RANDOM_EN
        // Burst starts only on frames where the reference LFSR low bits are zero.
        resetDut();
        lfsrRef = 16'hACE1;
        phase   = 0;
        for (int f = 0; f < 300; f++) begin
            if (phase == 0) begin
                ef = (lfsrRef[1:0] == 2'b00);
                st = ef ? "B" : "I";
            end else begin
                ef = (patP[phase] == "1");
                st = patS[phase];
            end
            if (phase != 0 || ef) phase = (phase + 1) % 10;
            frame(1'b1, 1'b1, ef, st);
            lfsrRef = {lfsrRef[0] ^ lfsrRef[2] ^ lfsrRef[3] ^ lfsrRef[5], lfsrRef[15:1]};
        end
`else
        // Request and slot held: bursts at 0,2,4 then cooldown, repeating every 10 frames.
        runTable("101010000010101000001", "BBBBCCCCCIBBBBCCCCCIB",
                 "111111111111111111111", "111111111111111111111");
        check("shot_count_after_frame20", {24'd0, shot_count}, 32'd7);

        // No free slot at frame 2: shot slips to 3, third at 5, next burst at 11.
        resetDut();
        runTable("100101000001", "BBBBBCCCCCIB", "111111111111", "110111111111");

        // Request dropped at frame 2: immediate cooldown, next shot at frame 8.
        resetDut();
        runTable("100000001", "BBCCCCCIB", "110111111", "111111111");

        // Reset held across frame 2 aborts the burst; frame 3 starts a fresh one.
        resetDut();
        runTable("10", "BB", "11", "11");
        @(negedge clk);
        reset    = 1'b1;
        expCount = 8'd0;
        frame(1'b1, 1'b1, 1'b0, "I");
        reset    = 1'b0;
        runTable("10101", "BBBBC", "11111", "11111");

        // 300 pulses over 1000 frames: shot_count wraps to 44.
        resetDut();
        for (int f = 0; f < 1000; f++) begin
            frame(1'b1, 1'b1, patP[f % 10] == "1", patS[f % 10]);
        end
        check("shot_count_wrap", {24'd0, shot_count}, 32'd44);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
